// File: rtl/alu_mdu_seq.sv
// Registered execute-stage ALU with an iterative RV32M multiply/divide engine.
// Base ops finish one cycle after accept; M ops share a shift/add-subtract datapath.
module alu_mdu_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    ALUResult
);

  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [4:0]      op;
  logic            accept, is_mop;
  logic [SW-1:0]   shamt;
  logic [W-1:0]    base_res;

  logic            mul_sa, mul_sb, div_s, a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;

  logic [2:0]      m_op;
  logic [2*W-1:0]  acc;
  logic [W-1:0]    mcand, a_keep, res_q;
  logic            neg_q, neg_r, b_zero;
  logic [SW-1:0]   cnt;

  logic [W:0]      mul_sum, div_tmp;
  logic [W-1:0]    div_diff, quot, rem, m_res;
  logic            div_ok;
  logic [2*W-1:0]  mul_next, div_next, prod;

  assign op        = Operation[4:0];
  assign accept    = in_valid && in_ready;
  assign is_mop    = op[4] && !op[3];
  assign shamt     = SrcB[SW-1:0];
  assign in_ready  = (state != BUSY);
  assign out_valid = (state == DONE);
  assign ALUResult = res_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    base_res = '0;
    case (op)
      5'b00000: base_res = SrcA & SrcB;
      5'b00001: base_res = SrcA | SrcB;
      5'b00100: base_res = SrcA ^ SrcB;
      5'b00101: base_res = SrcA + SrcB;
      5'b00011: base_res = SrcA - SrcB;
      5'b01000: base_res = W'(SrcA == SrcB);
      5'b01001: base_res = W'(SrcA != SrcB);
      5'b01010: base_res = W'($signed(SrcA) <  $signed(SrcB));
      5'b01011: base_res = W'($signed(SrcA) >= $signed(SrcB));
      5'b01111: base_res = W'(SrcA <  SrcB);
      5'b00010: base_res = W'(SrcA >= SrcB);
      5'b01100: base_res = SrcA >> shamt;
      5'b01101: base_res = SrcA << shamt;
      5'b01110: base_res = $unsigned($signed(SrcA) >>> shamt);
      default:  base_res = '0;
    endcase
  end

  // Operand signedness: MUL/MULH/MULHSU treat A as signed, only MUL/MULH treat B as signed.
  always_comb begin
    mul_sa = (op[1:0] != 2'b11);
    mul_sb = !op[1];
    div_s  = !op[0];
    a_neg  = SrcA[W-1] & (op[2] ? div_s : mul_sa);
    b_neg  = SrcB[W-1] & (op[2] ? div_s : mul_sb);
    a_mag  = a_neg ? -SrcA : SrcA;
    b_mag  = b_neg ? -SrcB : SrcB;
  end

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_next = {mul_sum, acc[W-1:1]};
    div_tmp  = {acc[2*W-1:W], acc[W-1]};
    div_ok   = (div_tmp >= {1'b0, mcand});
    div_diff = div_tmp[W-1:0] - mcand;
    div_next = {(div_ok ? div_diff : div_tmp[W-1:0]), acc[W-2:0], div_ok};
    prod     = neg_q ? -mul_next : mul_next;
    quot     = neg_q ? -div_next[W-1:0] : div_next[W-1:0];
    rem      = neg_r ? -div_next[2*W-1:W] : div_next[2*W-1:W];
    case (m_op)
      3'b000:          m_res = prod[W-1:0];
      3'b100, 3'b101:  m_res = b_zero ? '1 : quot;
      3'b110, 3'b111:  m_res = b_zero ? a_keep : rem;
      default:         m_res = prod[2*W-1:W];
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BUSY:    if (cnt == SW'(W-1)) state_nxt = DONE;
      default: state_nxt = accept ? (is_mop ? BUSY : DONE) : IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_op   <= '0;
      acc    <= '0;
      mcand  <= '0;
      a_keep <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      cnt    <= '0;
      res_q  <= '0;
    end else if (accept) begin
      cnt    <= '0;
      m_op   <= op[2:0];
      a_keep <= SrcA;
      b_zero <= (SrcB == '0);
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg & op[2];
      if (is_mop) begin
        acc   <= {{W{1'b0}}, (op[2] ? a_mag : b_mag)};
        mcand <= op[2] ? b_mag : a_mag;
      end else begin
        res_q <= base_res;
      end
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      acc <= m_op[2] ? div_next : mul_next;
      if (cnt == SW'(W-1)) res_q <= m_res;
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Scoreboard bench for alu_mdu_seq: the driver queues expected results and output cycles,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_alu_mdu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [4:0]  Operation = '0;
  logic        out_valid;
  logic [31:0] ALUResult;

  typedef struct {
    string       name;
    logic [31:0] val;
    int          obs;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   run_low = 0;
  int   e_div;
  int   dummy;

  alu_mdu_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .out_valid(out_valid), .ALUResult(ALUResult)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Drive one request and hold it until accepted; obs is the cycle count at the
  // negedge where out_valid should be seen (accept edge + latency - 1).
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name, input int lat,
                       input int fixed_obs, input bit push, output int acc_edge);
    int k;
    exp_t ent;
    @(negedge clk);
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    k = 0;
    while (in_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (in_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s_accept_timeout got=in_ready_low expected=accept", name);
      acc_edge = -1;
    end else begin
      acc_edge = cyc + 1;
      if (push) begin
        ent.name = name;
        ent.val  = exp;
        ent.obs  = (fixed_obs >= 0) ? fixed_obs : acc_edge + lat - 1;
        sb.push_back(ent);
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic go(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp, input string name, input int lat);
    int acc;
    issue(op, a, b, exp, name, lat, -1, 1'b1, acc);
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out_valid cyc=%0d got=%h expected=no_pulse", cyc, ALUResult);
      end else begin
        e_mon = sb.pop_front();
        check({e_mon.name, "_value"}, ALUResult, e_mon.val);
        check({e_mon.name, "_cycle"}, cyc, e_mon.obs);
      end
    end
    if (in_ready === 1'b0) begin
      run_low++;
    end else begin
      if (run_low > 0 && out_valid === 1'b1) check("busy_len", run_low, 32);
      run_low = 0;
    end
  end

  initial begin
    in_valid = 1'b1; Operation = 5'b00101; SrcA = 32'd1; SrcB = 32'd1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", ALUResult, 32'd0);
    reset = 1'b0; in_valid = 1'b0;

    go(5'b00101, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0002, "add", 1);
    go(5'b01010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "lt", 1);
    go(5'b01111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "ltu", 1);
    go(5'b01011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "ge", 1);
    go(5'b00011, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, "sub", 1);
    go(5'b01110, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, "sra", 1);
    go(5'b01100, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, "srl", 1);
    go(5'b01101, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, "sll", 1);
    go(5'b01000, 32'h1234_5678, 32'h1234_5678, 32'h0000_0001, "eq", 1);
    go(5'b00110, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, "unlisted_base", 1);
    go(5'b00001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, "or", 1);
    go(5'b11000, 32'h0000_0007, 32'h0000_0003, 32'h0000_0000, "unlisted_m", 1);

    go(5'b10000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul", 33);
    go(5'b10001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "mulh", 33);
    go(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu", 33);
    go(5'b10010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "mulhsu", 33);
    go(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf", 33);
    go(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf", 33);
    go(5'b10101, 32'd100,       32'h0000_0000, 32'hFFFF_FFFF, "divu_zero", 33);
    go(5'b10111, 32'd100,       32'h0000_0000, 32'd100,       "remu_zero", 33);
    go(5'b10110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_neg", 33);
    go(5'b10100, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, "div_mixed", 33);
    go(5'b10110, 32'd20,        32'hFFFF_FFFD, 32'h0000_0002, "rem_mixed", 33);

    // XOR request is held valid through the whole divide and must land right after it.
    issue(5'b10100, 32'd100, 32'd7, 32'd14, "div_hold", 33, -1, 1'b1, e_div);
    issue(5'b00100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor_hold", 1,
          e_div + 33, 1'b1, dummy);

    for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    issue(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, "mulhu_abort", 33, -1, 1'b0, dummy);
    repeat (5) @(negedge clk);
    check("busy_result_hold", ALUResult, 32'h0FF0_0FF0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_result", ALUResult, 32'd0);
    reset = 1'b0;
    repeat (45) @(negedge clk);
    check("abort_no_result", ALUResult, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
